// File: rtl/uurisc_pkg.sv
// Shared types and default parameters for the move-only execution unit.
// Instruction word layout: {mode[1:0], write_addr, read_addr}.
package uurisc_pkg;

  localparam int DEF_DATA_WIDTH       = 16;
  localparam int DEF_ADDR_WIDTH       = 16;
  localparam int DEF_INSTR_ADDR_WIDTH = 16;

  localparam logic [15:0] DEF_PC_MEM_ADDR   = 16'h8000;
  localparam logic [15:0] DEF_HALT_MEM_ADDR = 16'h8001;
  localparam logic [15:0] DEF_COND_MEM_ADDR = 16'h8002;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_MOV  = 2'b00,
    MODE_IMM  = 2'b01,
    MODE_CMOV = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

endpackage

// File: rtl/move_exec_unit.sv
// Transport-triggered execution unit: every instruction moves one value to a
// destination; a few destination addresses act as PC, halt and condition registers.
module move_exec_unit
  import uurisc_pkg::*;
#(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int INSTR_ADDR_WIDTH = DEF_INSTR_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] PC_MEM_ADDR   = ADDR_WIDTH'(DEF_PC_MEM_ADDR),
  parameter logic [ADDR_WIDTH-1:0] HALT_MEM_ADDR = ADDR_WIDTH'(DEF_HALT_MEM_ADDR),
  parameter logic [ADDR_WIDTH-1:0] COND_MEM_ADDR = ADDR_WIDTH'(DEF_COND_MEM_ADDR)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  output logic                        busy,
  output logic                        halted,
  output logic                        illegal,
  output logic                        instr_req,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_addr,
  input  logic [2+2*ADDR_WIDTH-1:0]   instr_din,
  input  logic                        instr_ack,
  output logic                        data_req,
  output logic                        data_we,
  output logic [ADDR_WIDTH-1:0]       data_addr,
  output logic [DATA_WIDTH-1:0]       data_dout,
  input  logic [DATA_WIDTH-1:0]       data_din,
  input  logic                        data_ack,
  output state_t                      dbg_state
);

  localparam int INSTR_WIDTH = 2 + 2 * ADDR_WIDTH;

  // Handshake (both ports): req rises with addr/we/dout valid and holds them
  // unchanged until a rising edge sees ack=1; ack may arrive in the req cycle,
  // and read data is captured on that same edge.

  state_t                      r_state;
  state_t                      w_next;
  logic [INSTR_ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0]       r_cond;
  logic [DATA_WIDTH-1:0]       r_value;
  logic [ADDR_WIDTH-1:0]       r_waddr;
  logic [ADDR_WIDTH-1:0]       r_raddr;
  logic                        r_illegal;

  mode_t                       w_mode;
  logic [ADDR_WIDTH-1:0]       w_din_waddr;
  logic [ADDR_WIDTH-1:0]       w_din_raddr;
  logic                        w_cond_true;
  logic                        w_dest_pc;
  logic                        w_dest_halt;
  logic                        w_dest_cond;
  logic                        w_mem_write;
  logic [INSTR_ADDR_WIDTH-1:0] w_pc_inc;
  state_t                      w_retire_state;

  assign w_mode         = mode_t'(instr_din[INSTR_WIDTH-1 -: 2]);
  assign w_din_waddr    = instr_din[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign w_din_raddr    = instr_din[ADDR_WIDTH-1:0];
  assign w_cond_true    = (r_cond != '0);
  assign w_dest_pc      = (r_waddr == PC_MEM_ADDR);
  assign w_dest_halt    = (r_waddr == HALT_MEM_ADDR);
  assign w_dest_cond    = (r_waddr == COND_MEM_ADDR);
  assign w_mem_write    = !w_dest_pc && !w_dest_halt;
  assign w_pc_inc       = r_pc + INSTR_ADDR_WIDTH'(1);
  assign w_retire_state = run ? ST_FETCH : ST_IDLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (run) w_next = ST_FETCH;
      ST_FETCH: begin
        if (instr_ack) begin
          case (w_mode)
            MODE_MOV:  w_next = ST_READ;
            MODE_IMM:  w_next = ST_WRITE;
            MODE_CMOV: w_next = w_cond_true ? ST_READ : w_retire_state;
            default:   w_next = w_retire_state;
          endcase
        end
      end
      ST_READ:  if (data_ack) w_next = ST_WRITE;
      ST_WRITE: begin
        if (w_dest_halt)                 w_next = ST_HALT;
        else if (w_dest_pc || data_ack)  w_next = w_retire_state;
      end
      ST_HALT:  if (!run) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= '0;
      r_cond    <= '0;
      r_value   <= '0;
      r_waddr   <= '0;
      r_raddr   <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (instr_ack) begin
            r_waddr <= w_din_waddr;
            r_raddr <= w_din_raddr;
            if (w_mode == MODE_IMM) r_value <= DATA_WIDTH'(w_din_raddr);
            if (w_mode == MODE_RSVD) begin
              r_illegal <= 1'b1;
              r_pc      <= w_pc_inc;
            end
            if (w_mode == MODE_CMOV && !w_cond_true) r_pc <= w_pc_inc;
          end
        end
        ST_READ: if (data_ack) r_value <= data_din;
        ST_WRITE: begin
          // Jumps and halts never reach memory; everything else retires on write ack.
          if (w_dest_pc) begin
            r_pc <= INSTR_ADDR_WIDTH'(r_value);
          end else if (w_dest_halt) begin
            r_pc <= w_pc_inc;
          end else if (data_ack) begin
            r_pc <= w_pc_inc;
            if (w_dest_cond) r_cond <= r_value;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    instr_req  = (r_state == ST_FETCH);
    instr_addr = r_pc;
    data_req   = (r_state == ST_READ) || ((r_state == ST_WRITE) && w_mem_write);
    data_we    = (r_state == ST_WRITE) && w_mem_write;
    data_addr  = (r_state == ST_READ) ? r_raddr : r_waddr;
    data_dout  = r_value;
    busy       = (r_state != ST_IDLE);
    halted     = (r_state == ST_HALT);
    illegal    = r_illegal;
    dbg_state  = r_state;
  end

endmodule
